// File: rtl/gmii_rx_framer_if.sv
// rtl/gmii_rx_framer_if.sv - GMII receive inputs and packed frame beat outputs
// The framer takes the slave side; the source/sink of the bytes takes the master side.
interface gmii_rx_framer_if #(
   parameter int BYTES = 4,
   parameter int CNT_W = 16
);
   logic [7:0]         RX_D;
   logic               RX_EN;
   logic               RX_ERR;
   logic               o_valid;
   logic [8*BYTES-1:0] o_data;
   logic [BYTES-1:0]   o_keep;
   logic               o_last;
   logic [CNT_W-1:0]   o_byte_cnt;
   logic [2:0]         o_status;
   logic               o_err;
   logic [CNT_W-1:0]   o_drop_cnt;

   modport slave (
      input  RX_D, RX_EN, RX_ERR,
      output o_valid, o_data, o_keep, o_last, o_byte_cnt, o_status, o_err, o_drop_cnt
   );

   modport master (
      output RX_D, RX_EN, RX_ERR,
      input  o_valid, o_data, o_keep, o_last, o_byte_cnt, o_status, o_err, o_drop_cnt
   );
endinterface

// File: rtl/gmii_rx_framer.sv
// rtl/gmii_rx_framer.sv - GMII receive framer: strips preamble/SFD, packs bytes into beats
// Each completed beat is held one byte-time so the final beat of a frame can carry o_last.
module gmii_rx_framer #(
   parameter int BYTES   = 4,
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518,
   parameter int CNT_W   = 16
) (
   input  logic             CLK,
   input  logic             RST,
   gmii_rx_framer_if.slave  gmii
);
   typedef enum logic [2:0] {WAIT, IDLE, PRE, DATA, DROP} state_t;

   localparam logic [7:0]       PREAMBLE = 8'h55;
   localparam logic [7:0]       SFD      = 8'hD5;
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] MAXP1_C  = CNT_W'(MAX_LEN + 1);
   localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_LEN);
   localparam logic [CNT_W-1:0] BYTES_C  = CNT_W'(BYTES);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [8*BYTES-1:0] acc_q, acc_d;
   logic [8*BYTES-1:0] pend_q, pend_d;
   logic               err_q, err_d;
   logic               ovf_q, ovf_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic               valid_q, valid_d;
   logic [8*BYTES-1:0] data_q, data_d;
   logic [BYTES-1:0]   keep_q, keep_d;
   logic               last_q, last_d;
   logic [CNT_W-1:0]   bcnt_q, bcnt_d;
   logic [2:0]         status_q, status_d;

   logic [CNT_W-1:0]   packed_cnt;
   logic [CNT_W-1:0]   lane;
   logic [CNT_W-1:0]   drop_inc;
   logic [BYTES-1:0]   part_keep;

   always_comb begin
      packed_cnt = (cnt_q > MAX_C) ? MAX_C : cnt_q;
      lane       = packed_cnt % BYTES_C;
      drop_inc   = (&drop_q) ? drop_q : drop_q + ONE_C;
      for (int i = 0; i < BYTES; i++) begin
         part_keep[i] = (CNT_W'(i) < lane);
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      pend_d   = pend_q;
      err_d    = err_q;
      ovf_d    = ovf_q;
      drop_d   = drop_q;
      valid_d  = 1'b0;
      data_d   = '0;
      keep_d   = '0;
      last_d   = 1'b0;
      bcnt_d   = '0;
      status_d = '0;

      case (state_q)
         WAIT: begin
            if (!gmii.RX_EN) state_d = IDLE;
         end
         IDLE: begin
            if (gmii.RX_EN) begin
               if (gmii.RX_D == PREAMBLE) begin
                  state_d = PRE;
                  cnt_d   = '0;
                  acc_d   = '0;
                  err_d   = 1'b0;
                  ovf_d   = 1'b0;
               end else begin
                  state_d = DROP;
               end
            end
         end
         PRE: begin
            if (!gmii.RX_EN)                state_d = IDLE;
            else if (gmii.RX_D == SFD)      state_d = DATA;
            else if (gmii.RX_D != PREAMBLE) state_d = DROP;
         end
         DATA: begin
            if (gmii.RX_EN) begin
               if (cnt_q != MAXP1_C) cnt_d = cnt_q + ONE_C;
               if (gmii.RX_ERR) err_d = 1'b1;
               if (cnt_q >= MAX_C) begin
                  ovf_d = 1'b1;
               end else begin
                  // A byte landing in lane 0 proves the held beat is not the frame's last.
                  if (lane == '0 && cnt_q != '0) begin
                     valid_d = 1'b1;
                     data_d  = pend_q;
                     keep_d  = '1;
                  end
                  for (int i = 0; i < BYTES; i++) begin
                     if (lane == CNT_W'(i)) acc_d[8*i +: 8] = gmii.RX_D;
                  end
                  if (lane == BYTES_C - ONE_C) begin
                     pend_d = acc_d;
                     acc_d  = '0;
                  end
               end
            end else begin
               state_d = IDLE;
               if (cnt_q == '0) begin
                  drop_d = drop_inc;
               end else begin
                  valid_d  = 1'b1;
                  last_d   = 1'b1;
                  bcnt_d   = packed_cnt;
                  status_d = {ovf_q, (cnt_q < MIN_C), err_q};
                  if (lane != '0) begin
                     data_d = acc_q;
                     keep_d = part_keep;
                  end else begin
                     data_d = pend_q;
                     keep_d = '1;
                  end
               end
            end
         end
         DROP: begin
            if (!gmii.RX_EN) begin
               state_d = IDLE;
               drop_d  = drop_inc;
            end
         end
         default: state_d = WAIT;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= WAIT;
         cnt_q    <= '0;
         acc_q    <= '0;
         pend_q   <= '0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         keep_q   <= '0;
         last_q   <= 1'b0;
         bcnt_q   <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         pend_q   <= pend_d;
         err_q    <= err_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         keep_q   <= keep_d;
         last_q   <= last_d;
         bcnt_q   <= bcnt_d;
         status_q <= status_d;
      end
   end

   assign gmii.o_valid    = valid_q;
   assign gmii.o_data     = data_q;
   assign gmii.o_keep     = keep_q;
   assign gmii.o_last     = last_q;
   assign gmii.o_byte_cnt = bcnt_q;
   assign gmii.o_status   = status_q;
   assign gmii.o_err      = |status_q;
   assign gmii.o_drop_cnt = drop_q;
endmodule

// File: tb/tb_gmii_rx_framer.sv
// tb/tb_gmii_rx_framer.sv - scoreboard bench for gmii_rx_framer with BYTES=4
module tb_gmii_rx_framer;
   localparam int BYTES   = 4;
   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;
   localparam int CNT_W   = 16;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic [15:0] cnt;
      logic [2:0]  st;
   } beat_t;

   logic  CLK = 1'b0;
   logic  RST;
   beat_t exp_q[$];
   beat_t mon_e;
   logic [31:0] mon_m;
   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int beats_seen = 0;
   int last_cyc = -1;
   int end_cyc = 0;
   int exp_drop = 0;

   always #4 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   gmii_rx_framer_if #(.BYTES(BYTES), .CNT_W(CNT_W)) gif ();

   gmii_rx_framer #(
      .BYTES(BYTES), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)
   ) dut (
      .CLK  (CLK),
      .RST  (RST),
      .gmii (gif)
   );

   always @(negedge CLK) begin
      if (!RST && gif.o_valid) begin
         beats_seen++;
         if (gif.o_last) last_cyc = cyc;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat data=%h keep=%h last=%b (no beat expected)",
                     gif.o_data, gif.o_keep, gif.o_last);
         end else begin
            mon_e = exp_q.pop_front();
            for (int i = 0; i < 4; i++) mon_m[8*i +: 8] = {8{mon_e.keep[i]}};
            if ((gif.o_data & mon_m) !== mon_e.data || gif.o_keep !== mon_e.keep ||
                gif.o_last !== mon_e.last) begin
               n_fail++;
               $display("FAIL beat got data=%h keep=%h last=%b expected data=%h keep=%h last=%b",
                        gif.o_data & mon_m, gif.o_keep, gif.o_last,
                        mon_e.data, mon_e.keep, mon_e.last);
            end
            if (mon_e.last) begin
               n_checks++;
               if (gif.o_byte_cnt !== mon_e.cnt || gif.o_status !== mon_e.st ||
                   gif.o_err !== (|mon_e.st)) begin
                  n_fail++;
                  $display("FAIL last_fields got cnt=%0d st=%b err=%b expected cnt=%0d st=%b err=%b",
                           gif.o_byte_cnt, gif.o_status, gif.o_err,
                           mon_e.cnt, mon_e.st, |mon_e.st);
               end
            end
         end
      end else if (!RST) begin
         n_checks++;
         if (gif.o_keep !== 4'h0 || gif.o_last !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_outputs got keep=%h last=%b expected keep=0 last=0",
                     gif.o_keep, gif.o_last);
         end
      end
   end

   task automatic drive(input logic [7:0] d, input logic en, input logic er);
      gif.RX_D   = d;
      gif.RX_EN  = en;
      gif.RX_ERR = er;
      @(posedge CLK);
      #1;
   endtask

   task automatic push_frame(input int n, input int err_idx);
      beat_t b;
      int p;
      p = (n > MAX_LEN) ? MAX_LEN : n;
      for (int s = 0; s < p; s += 4) begin
         b.data = '0;
         b.keep = '0;
         for (int k = 0; k < 4; k++) begin
            if (s + k < p) begin
               b.data[8*k +: 8] = 8'(s + k + 1);
               b.keep[k] = 1'b1;
            end
         end
         b.last = (s + 4 >= p);
         b.cnt  = 16'(p);
         b.st   = {n > MAX_LEN, n < MIN_LEN, (err_idx >= 0 && err_idx < n)};
         exp_q.push_back(b);
      end
   endtask

   task automatic send_frame(input int n, input int err_idx);
      for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
      drive(8'hD5, 1'b1, 1'b0);
      for (int i = 0; i < n; i++) drive(8'(i + 1), 1'b1, i == err_idx);
      drive(8'h00, 1'b0, 1'b0);
      end_cyc = cyc;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge CLK);
      drive(8'h00, 1'b0, 1'b0);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain got %0d beats outstanding expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      gif.RX_D = 8'h55; gif.RX_EN = 1'b1; gif.RX_ERR = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      n_checks++;
      if ({gif.o_valid, gif.o_data, gif.o_keep, gif.o_last, gif.o_byte_cnt,
           gif.o_status, gif.o_err, gif.o_drop_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got valid=%b data=%h drop=%0d expected all zero",
                  gif.o_valid, gif.o_data, gif.o_drop_cnt);
      end
   endtask

   task automatic test_wait();
      int b0;
      b0 = beats_seen;
      @(posedge CLK); #1;
      RST = 1'b0;
      for (int i = 0; i < 30; i++) drive(8'(i == 3 ? 8'hD5 : 8'h55 + i), 1'b1, 1'b0);
      drive(8'h00, 1'b0, 1'b0);
      drive(8'h00, 1'b0, 1'b0);
      check_int("wait_no_beats", beats_seen - b0, 0);
      check_int("wait_no_drop", int'(gif.o_drop_cnt), exp_drop);
   endtask

   task automatic test_frame(input string name, input int n, input int err_idx, input int nbeats);
      int b0;
      b0 = beats_seen;
      push_frame(n, err_idx);
      send_frame(n, err_idx);
      wait_drain(name);
      check_int({name, "_beats"}, beats_seen - b0, nbeats);
      check_int({name, "_last_timing"}, last_cyc, end_cyc);
   endtask

   task automatic test_carrier_ext();
      for (int i = 0; i < 5; i++) drive(8'h0F, 1'b0, 1'b1);
      test_frame("carrier_ext", 64, -1, 16);
      check_int("carrier_ext_drop", int'(gif.o_drop_cnt), exp_drop);
   endtask

   task automatic test_drops();
      int b0;
      b0 = beats_seen;
      drive(8'h55, 1'b1, 1'b0); drive(8'h12, 1'b1, 1'b0); drive(8'h34, 1'b1, 1'b0);
      drive(8'h00, 1'b0, 1'b0);
      exp_drop++;
      check_int("drop_bad_sfd", int'(gif.o_drop_cnt), exp_drop);
      drive(8'h55, 1'b1, 1'b0); drive(8'hD5, 1'b1, 1'b0);
      drive(8'h00, 1'b0, 1'b0);
      exp_drop++;
      check_int("drop_empty_frame", int'(gif.o_drop_cnt), exp_drop);
      drive(8'hD5, 1'b1, 1'b0); drive(8'h01, 1'b1, 1'b0); drive(8'h02, 1'b1, 1'b0);
      drive(8'h00, 1'b0, 1'b0);
      exp_drop++;
      check_int("drop_sfd_in_idle", int'(gif.o_drop_cnt), exp_drop);
      drive(8'h55, 1'b1, 1'b0); drive(8'h55, 1'b1, 1'b0);
      drive(8'h00, 1'b0, 1'b0);
      check_int("pre_abort_no_drop", int'(gif.o_drop_cnt), exp_drop);
      drive(8'h00, 1'b0, 1'b0);
      check_int("drops_no_beats", beats_seen - b0, 0);
   endtask

   task automatic test_reset_mid();
      int b0;
      b0 = beats_seen;
      push_frame(40, -1);
      for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
      drive(8'hD5, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) drive(8'(i + 1), 1'b1, 1'b0);
      gif.RX_D = 8'd21;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      exp_drop = 0;
      check_int("reset_mid_outstanding", exp_q.size(), 6);
      exp_q.delete();
      for (int i = 21; i < 40; i++) drive(8'(i + 1), 1'b1, 1'b0);
      drive(8'h00, 1'b0, 1'b0);
      drive(8'h00, 1'b0, 1'b0);
      check_int("reset_mid_beats", beats_seen - b0, 4);
      check_int("reset_mid_drop", int'(gif.o_drop_cnt), 0);
      test_frame("after_reset", 64, -1, 16);
   endtask

   task automatic test_back_to_back();
      int b0;
      b0 = beats_seen;
      push_frame(64, -1);
      push_frame(70, -1);
      send_frame(64, -1);
      send_frame(70, -1);
      wait_drain("b2b");
      check_int("b2b_beats", beats_seen - b0, 34);
      check_int("b2b_last_timing", last_cyc, end_cyc);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_wait();
      test_frame("len64", 64, -1, 16);
      test_frame("len65", 65, -1, 17);
      test_frame("rx_err", 10, 4, 3);
      test_carrier_ext();
      test_frame("oversize", 1600, -1, 380);
      test_drops();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/gmii_rx_framer.md
GMII_RX_FRAMER -- requirements
Module: gmii_rx_framer

Interface
REQ-001 Parameter BYTES, default 4, sets output beat width in bytes; legal values are 1, 2, 4 or 8.
REQ-002 Parameter MIN_LEN, default 64, sets the runt threshold in post-SFD bytes.
REQ-003 Parameter MAX_LEN, default 1518, sets the oversize threshold in post-SFD bytes.
REQ-004 Parameter CNT_W, default 16, sets the width of the byte and drop counters; CNT_W SHALL exceed clog2(MAX_LEN+1).
REQ-005 CLK, input, 1: the single clock (GMII receive clock, 125 MHz); every flop SHALL be on its rising edge.
REQ-006 RST, input, 1: reset, asynchronous and active-high.
REQ-007 RX_D, input, 8: GMII receive byte.
REQ-008 RX_EN, input, 1: GMII receive data valid.
REQ-009 RX_ERR, input, 1: GMII receive error.
REQ-010 o_valid, output, 1: beat strobe; there is no backpressure.
REQ-011 o_data, output, 8*BYTES: packed frame bytes; the first byte goes in lane 0 (bits 7:0).
REQ-012 o_keep, output, BYTES: lane-valid mask, contiguous from lane 0.
REQ-013 o_last, output, 1: final beat of a frame.
REQ-014 o_byte_cnt, output, CNT_W: post-SFD byte count; valid only when o_last=1.
REQ-015 o_status, output, 3: {oversize, runt, rx_err}; valid only when o_last=1.
REQ-016 o_err, output, 1: OR of o_status; valid only when o_last=1.
REQ-017 o_drop_cnt, output, CNT_W: saturating count of frames dropped before any data was emitted.

Function
REQ-018 The FSM SHALL have exactly five states: WAIT, IDLE, PRE, DATA, DROP.
REQ-019 WAIT SHALL move to IDLE on the first cycle RX_EN=0, so that a frame already in progress at reset release is ignored.
REQ-020 IDLE with RX_EN=1 SHALL go to PRE on RX_D=0x55 and to DROP on any other byte, including 0xD5.
REQ-021 PRE with RX_EN=1 SHALL stay in PRE on 0x55, go to DATA on 0xD5 (the SFD), and go to DROP on any other byte.
REQ-022 PRE with RX_EN=0 SHALL return to IDLE with no output and no drop count.
REQ-023 DROP SHALL ignore all input until RX_EN=0, then go to IDLE and increment o_drop_cnt, saturating at all-ones.
REQ-024 In DATA, every byte with RX_EN=1 SHALL be accepted; preamble and SFD bytes SHALL never appear on o_data.
REQ-025 Accepted bytes SHALL be packed into an accumulator at lane (count mod BYTES).
REQ-026 A completed beat SHALL be held in a pending register.
REQ-027 The pending beat SHALL be emitted with o_last=0 and o_keep all-ones in the cycle after the edge that samples the next accepted byte.
REQ-028 Frame end SHALL be the first edge in DATA that samples RX_EN=0; in the following cycle the block SHALL emit exactly one beat with o_last=1.
REQ-029 At frame end the final beat SHALL be the accumulator if it is non-empty (o_keep = low (count mod BYTES) bits set), otherwise the pending beat (o_keep all-ones).
REQ-030 A frame with zero post-SFD bytes SHALL produce no beat and SHALL increment o_drop_cnt.
REQ-031 The byte counter SHALL count every accepted byte and saturate at MAX_LEN+1.
REQ-032 Bytes beyond MAX_LEN SHALL be discarded (not packed) and SHALL set the oversize flag.
REQ-033 RX_ERR=1 with RX_EN=1 in DATA SHALL set the rx_err flag; RX_ERR with RX_EN=0 (carrier extension) SHALL be ignored in every state.
REQ-034 runt SHALL be set when the final count is less than MIN_LEN.
REQ-035 o_byte_cnt on the last beat SHALL equal min(count, MAX_LEN).
REQ-036 After frame end the FSM SHALL be in IDLE, so a new preamble may start on the cycle immediately after RX_EN=0.
REQ-037 Outside emitted beats, o_valid, o_last and o_keep SHALL be 0.
REQ-038 All flags and counters except o_drop_cnt SHALL clear at the start of each frame.

Reset
REQ-039 While RST=1, the FSM SHALL be in WAIT and all outputs SHALL be 0, including o_drop_cnt.
REQ-040 RST asserted mid-frame SHALL abort the frame with no o_last beat emitted.
REQ-041 The first output after reset release SHALL belong to a frame whose preamble starts after RX_EN has been seen low.

Verification
REQ-042 BYTES=4, 7x0x55, 0xD5, bytes 0x01..0x40 (64 bytes), RX_EN low -> 16 beats; beat 0 o_data=0x04030201; the last beat has o_keep=0xF, o_last=1, o_byte_cnt=64, o_status=0.
REQ-043 BYTES=4, 65 data bytes -> 17 beats; the last beat has o_keep=0x1, o_byte_cnt=65; o_last appears exactly 1 cycle after the edge sampling RX_EN=0.
REQ-044 BYTES=4, 10 data bytes with RX_ERR pulsed on byte 5 -> the last beat has o_keep=0x3, o_byte_cnt=10, o_status=3'b011, o_err=1.
REQ-045 BYTES=4, 1600 data bytes -> o_byte_cnt=1518, o_status=3'b100, and no more than 380 beats are emitted.
REQ-046 Cover drop and idle cases: 0x55, 0x12 (bad SFD) -> no beats, o_drop_cnt=1; 0x55, 0xD5, then RX_EN low -> o_drop_cnt=2; SFD-only preamble 0xD5 in IDLE -> DROP.
REQ-047 Cover reset cases: RST pulsed at byte 20 with RX_EN still high -> no beats until RX_EN falls and a fresh frame arrives, which is received intact; back-to-back frames with a 1-cycle gap -> both received.
